// File: rtl/fifo_pkg.sv
// Shared definitions for the TDP18K FIFO-mode read path: mode encodings,
// flag bit order and parameter legality helpers.
package fifo_pkg;

  localparam logic [2:0] MODE_18 = 3'b010;
  localparam logic [2:0] MODE_9  = 3'b100;

  localparam int FLAG_EMPTY    = 0;
  localparam int FLAG_EPO      = 1;
  localparam int FLAG_FULL     = 2;
  localparam int FLAG_FMO      = 3;
  localparam int FLAG_UNDERRUN = 4;
  localparam int FLAG_OVERFLOW = 5;
  localparam int FLAG_W        = 6;

  // The buffer must absorb every word already in flight when the consumer stalls.
  function automatic bit rd_params_legal(input int rd_latency, input int buf_depth,
                                         input int cnt_w);
    return ((rd_latency == 1) || (rd_latency == 2)) &&
           (buf_depth >= rd_latency + 1) &&
           ((1 << cnt_w) > buf_depth);
  endfunction

  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Circular skid buffer: head entry is presented combinationally, tail is
// written on push, occupancy tracked alongside the pointers.
module skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      occ,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (occ == '0);
  assign full  = (occ == CNT_W'(BUF_DEPTH));
  // A full buffer can still accept a word in the same cycle it hands one out.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= din;
        tail      <= PTR_W'(wrap_inc(int'(tail), BUF_DEPTH));
      end
      if (rd_en) head <= PTR_W'(wrap_inc(int'(head), BUF_DEPTH));
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port egress: converts EMPTY/EPO/REN/RDATA into a valid/ready
// stream using credit-based reads, a latency tracker and a skid buffer.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  CLK_i,
  input  logic                  RST_ni,
  input  logic                  FLUSH_ni,
  input  logic                  EMPTY_i,
  input  logic                  EPO_i,
  input  logic                  UNDERRUN_i,
  input  logic [DATA_WIDTH-1:0] RDATA_i,
  output logic                  REN_o,
  output logic [DATA_WIDTH-1:0] M_TDATA_o,
  output logic                  M_TVALID_o,
  input  logic                  M_TREADY_i,
  output logic [CNT_W-1:0]      OCC_o,
  output logic                  ERR_o
);

  localparam int SUM_W = CNT_W + 2;

  if (!rd_params_legal(RD_LATENCY, BUF_DEPTH, CNT_W)) begin : g_bad_params
    $error("fifo_rd_stream: illegal RD_LATENCY/BUF_DEPTH/CNT_W combination");
  end

  logic                  flush;
  logic                  ren;
  logic                  ren_p1;
  logic                  epo_p1;
  logic                  pop;
  logic                  capture;
  logic                  overflow;
  logic                  buf_full;
  logic                  buf_empty;
  logic                  err_q;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [SUM_W-1:0]      inflight;
  logic [SUM_W-1:0]      credit_need;
  logic [CNT_W-1:0]      occ;

  assign flush = ~FLUSH_ni;
  assign pop   = M_TVALID_o & M_TREADY_i;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + SUM_W'(vld_pipe[i]);
  end

  // A pop frees a slot this cycle, so ready feeds REN combinationally.
  assign credit_need = SUM_W'(occ) + inflight - SUM_W'(pop);
  // EPO seen with a read last cycle means the flag may be stale: hold off one cycle.
  assign ren   = ~EMPTY_i & ~(ren_p1 & epo_p1) & (credit_need < SUM_W'(BUF_DEPTH)) & FLUSH_ni;
  assign REN_o = ren;

  assign capture  = vld_pipe[RD_LATENCY-1];
  assign overflow = capture & buf_full & ~pop;

  // Stage p0 -> p1: read strobe history and in-flight tracker.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      ren_p1   <= 1'b0;
      epo_p1   <= 1'b0;
      vld_pipe <= '0;
    end else if (flush) begin
      ren_p1   <= 1'b0;
      epo_p1   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      ren_p1   <= ren;
      epo_p1   <= EPO_i;
      vld_pipe <= RD_LATENCY'({vld_pipe, ren});
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (UNDERRUN_i || overflow) begin
      err_q <= 1'b1;
    end
  end

  skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_skid_buf (
    .clk   (CLK_i),
    .rst_n (RST_ni),
    .flush (flush),
    .push  (capture),
    .pop   (pop),
    .din   (RDATA_i),
    .dout  (M_TDATA_o),
    .occ   (occ),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign M_TVALID_o = ~buf_empty;
  assign OCC_o      = occ;
  assign ERR_o      = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO + consumer model, scoreboard on fixed read latency.
module tb_fifo_rd_stream;

  localparam int DW    = 18;
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          CLK_i      = 1'b0;
  logic          RST_ni     = 1'b1;
  logic          FLUSH_ni   = 1'b1;
  logic          EMPTY_i    = 1'b1;
  logic          EPO_i      = 1'b0;
  logic          UNDERRUN_i = 1'b0;
  logic [DW-1:0] RDATA_i    = '0;
  logic          M_TREADY_i = 1'b0;
  logic          REN_o;
  logic [DW-1:0] M_TDATA_o;
  logic          M_TVALID_o;
  logic [CW-1:0] OCC_o;
  logic          ERR_o;

  always #5 CLK_i = ~CLK_i;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .BUF_DEPTH  (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .CLK_i      (CLK_i),
    .RST_ni     (RST_ni),
    .FLUSH_ni   (FLUSH_ni),
    .EMPTY_i    (EMPTY_i),
    .EPO_i      (EPO_i),
    .UNDERRUN_i (UNDERRUN_i),
    .RDATA_i    (RDATA_i),
    .REN_o      (REN_o),
    .M_TDATA_o  (M_TDATA_o),
    .M_TVALID_o (M_TVALID_o),
    .M_TREADY_i (M_TREADY_i),
    .OCC_o      (OCC_o),
    .ERR_o      (ERR_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    int            rc;
  } rd_t;

  logic [DW-1:0] fq[$];
  rd_t           sq[$];
  logic [DW-1:0] outq[$];
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];
  int            cyc      = 0;
  int            prev_cnt = 0;
  bit            stale    = 1'b0;
  bit            err_m    = 1'b0;

  int ren_cnt, ren_run, max_run, pop_cnt, first_pop, last_pop;
  int max_occ, vld_cnt, first_ren, first_vld;

  task automatic clr_stats();
    ren_cnt = 0; ren_run = 0; max_run = 0; pop_cnt = 0;
    first_pop = -1; last_pop = -1; max_occ = 0;
    vld_cnt = 0; first_ren = -1; first_vld = -1;
    outq.delete();
  endtask

  task automatic model_clear();
    fq.delete();
    sq.delete();
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    err_m    = 1'b0;
    prev_cnt = 0;
    EMPTY_i  = 1'b1;
    EPO_i    = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fq.push_back(w);
    prev_cnt = fq.size();
    EMPTY_i  = 1'b0;
    EPO_i    = (fq.size() == 1);
  endtask

  task automatic step();
    logic s_ren, s_pop, s_flush, s_unf;
    int   exp_occ, cur, use_cnt;
    rd_t  r;
    @(negedge CLK_i);
    s_ren   = REN_o;
    s_pop   = M_TVALID_o & M_TREADY_i;
    s_flush = ~FLUSH_ni;
    s_unf   = UNDERRUN_i;
    exp_occ = 0;
    foreach (sq[i]) if (sq[i].rc + LAT + 1 <= cyc) exp_occ++;
    chk("occ", 32'(OCC_o), 32'(exp_occ));
    chk("tvalid", 32'(M_TVALID_o), 32'(exp_occ != 0));
    if (exp_occ != 0) chk("tdata", 32'(M_TDATA_o), 32'(sq[0].d));
    chk("err", 32'(ERR_o), 32'(err_m));
    if (s_ren) chk("ren_nonempty", 32'(fq.size() != 0), 32'd1);
    if (s_ren) begin
      ren_cnt++; ren_run++;
      if (ren_run > max_run) max_run = ren_run;
      if (first_ren < 0) first_ren = cyc;
    end else ren_run = 0;
    if (M_TVALID_o) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
    end
    if (s_pop) begin
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      outq.push_back(M_TDATA_o);
    end
    if (int'(OCC_o) > max_occ) max_occ = int'(OCC_o);

    @(posedge CLK_i);
    #1;
    if (s_pop && exp_occ != 0) void'(sq.pop_front());
    for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    pv[0] = 1'b0;
    pd[0] = '0;
    if (s_ren && fq.size() != 0) begin
      pd[0] = fq.pop_front();
      pv[0] = 1'b1;
      r.d   = pd[0];
      r.rc  = cyc;
      sq.push_back(r);
    end
    if (s_flush) begin
      fq.delete();
      sq.delete();
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      err_m = 1'b0;
    end else if (s_unf) begin
      err_m = 1'b1;
    end
    RDATA_i = pv[LAT-1] ? pd[LAT-1] : DW'($urandom);
    cur     = fq.size();
    use_cnt = stale ? prev_cnt : cur;
    EMPTY_i = (use_cnt == 0);
    EPO_i   = (use_cnt == 1);
    prev_cnt = cur;
    cyc++;
  endtask

  initial begin
    model_clear();
    clr_stats();
    #1 RST_ni = 1'b0;
    #2;
    chk("rst_ren", 32'(REN_o), 32'd0);
    chk("rst_tvalid", 32'(M_TVALID_o), 32'd0);
    chk("rst_tdata", 32'(M_TDATA_o), 32'd0);
    chk("rst_occ", 32'(OCC_o), 32'd0);
    chk("rst_err", 32'(ERR_o), 32'd0);
    repeat (2) @(posedge CLK_i);
    #1 RST_ni = 1'b1;

    // single word against a flag that lags one extra cycle
    clr_stats();
    stale = 1'b1;
    M_TREADY_i = 1'b1;
    load(18'h2A5A5);
    repeat (8) step();
    chk("sw_ren_cnt", 32'(ren_cnt), 32'd1);
    chk("sw_vld_cnt", 32'(vld_cnt), 32'd1);
    chk("sw_latency", 32'(first_vld - first_ren), 32'd2);
    chk("sw_pop_cnt", 32'(pop_cnt), 32'd1);
    if (outq.size() != 0) chk("sw_data", 32'(outq[0]), 32'h2A5A5);
    stale = 1'b0;

    // streaming at full rate
    clr_stats();
    for (int i = 0; i < 8; i++) load(DW'(i));
    repeat (14) step();
    chk("st_ren_cnt", 32'(ren_cnt), 32'd8);
    chk("st_ren_run", 32'(max_run), 32'd8);
    chk("st_pop_cnt", 32'(pop_cnt), 32'd8);
    chk("st_no_gap", 32'(last_pop - first_pop), 32'd7);
    chk("st_occ_max", 32'(max_occ <= 1), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < outq.size()) chk("st_order", 32'(outq[i]), 32'(i));

    // back-pressure
    clr_stats();
    M_TREADY_i = 1'b0;
    for (int i = 0; i < 4; i++) load(DW'(i));
    repeat (8) step();
    chk("bp_ren_cnt", 32'(ren_cnt), 32'd2);
    chk("bp_occ", 32'(OCC_o), 32'd2);
    chk("bp_tdata", 32'(M_TDATA_o), 32'd0);
    clr_stats();
    M_TREADY_i = 1'b1;
    repeat (12) step();
    chk("bp_pop_cnt", 32'(pop_cnt), 32'd4);
    chk("bp_no_gap", 32'(last_pop - first_pop), 32'd3);
    for (int i = 0; i < 4; i++)
      if (i < outq.size()) chk("bp_order", 32'(outq[i]), 32'(i));

    // flush with one word buffered and one in flight
    M_TREADY_i = 1'b0;
    load(18'h10); load(18'h11); load(18'h12);
    step();
    step();
    chk("fl_pre_occ", 32'(OCC_o), 32'd1);
    FLUSH_ni = 1'b0;
    step();
    FLUSH_ni = 1'b1;
    chk("fl_tvalid", 32'(M_TVALID_o), 32'd0);
    chk("fl_occ", 32'(OCC_o), 32'd0);
    clr_stats();
    M_TREADY_i = 1'b1;
    repeat (6) step();
    chk("fl_no_word", 32'(pop_cnt), 32'd0);

    // sticky underrun error
    UNDERRUN_i = 1'b1;
    step();
    UNDERRUN_i = 1'b0;
    chk("err_set", 32'(ERR_o), 32'd1);
    repeat (5) step();
    chk("err_hold", 32'(ERR_o), 32'd1);
    FLUSH_ni = 1'b0;
    step();
    FLUSH_ni = 1'b1;
    chk("err_clr", 32'(ERR_o), 32'd0);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(7) == 0 && fq.size() < 16) begin
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) load(DW'($urandom));
      end
      M_TREADY_i = ($urandom_range(3) != 0);
      FLUSH_ni   = ($urandom_range(59) != 0);
      UNDERRUN_i = ($urandom_range(79) == 0);
      step();
    end
    FLUSH_ni   = 1'b1;
    UNDERRUN_i = 1'b0;

    // asynchronous reset between edges while a word is presented
    FLUSH_ni = 1'b0;
    step();
    FLUSH_ni = 1'b1;
    M_TREADY_i = 1'b0;
    load(18'h15555);
    repeat (4) step();
    chk("ar_pre_tvalid", 32'(M_TVALID_o), 32'd1);
    #2 RST_ni = 1'b0;
    #1;
    chk("ar_tvalid", 32'(M_TVALID_o), 32'd0);
    chk("ar_tdata", 32'(M_TDATA_o), 32'd0);
    chk("ar_occ", 32'(OCC_o), 32'd0);
    chk("ar_ren", 32'(REN_o), 32'd0);
    chk("ar_err", 32'(ERR_o), 32'd0);
    model_clear();
    @(posedge CLK_i);
    #1 RST_ni = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
